// File: rtl/avalon_st_msg_generator_pkg.sv
// Shared types and helpers for the incrementing-byte Avalon-ST message generator.
// The generator and its beat builder both import this package.
package avalon_st_gen_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } gen_state_t;

  // Unused low lanes on the last beat of a len-byte message.
  function automatic int calc_empty(input int len, input int width);
    int rem_v;
    if (width <= 0) begin
      return 0;
    end else begin
      rem_v = len % width;
      return (width - rem_v) % width;
    end
  endfunction

  // Empty-field width; a single-lane bus still carries a 1-bit field.
  function automatic int empty_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/avalon_st_msg_generator_if.sv
// Avalon-ST style message stream: big-endian byte lanes, sop/eop framing,
// empty count on the eop beat, and valid/rdy flow control.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
);
  import avalon_st_gen_pkg::*;

  localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);

  logic [BYTE_W*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                                  sop;
  logic                                  eop;
  logic [EMPTY_W-1:0]                    empty;
  logic                                  valid;
  logic                                  rdy;

  modport master (output data, sop, eop, empty, valid, input rdy);
  modport slave  (input data, sop, eop, empty, valid, output rdy);

endinterface

// File: rtl/avalon_st_msg_generator_pattern_beat.sv
// Combinational beat builder: fills lanes with (first_byte + byte_cnt + lane) mod 256,
// zeroes lanes past the end of the message and reports the last-beat empty count.
module avalon_st_pattern_beat
  import avalon_st_gen_pkg::*;
#(
  parameter int W       = 4,
  parameter int CNT_W   = 11,
  parameter int EMPTY_W = 2
) (
  input  logic [BYTE_W-1:0]   first_byte,
  input  logic [CNT_W-1:0]    byte_cnt,
  input  logic [CNT_W-1:0]    remaining,
  output logic [BYTE_W*W-1:0] data,
  output logic [EMPTY_W-1:0]  empty,
  output logic                last
);

  logic [BYTE_W-1:0] base_s;

  assign base_s = first_byte + BYTE_W'(byte_cnt);

  // Lane fill: byte 0 of the beat occupies the most significant lane.
  always_comb begin
    data = '0;
    for (int i = 0; i < W; i++) begin
      if (CNT_W'(i) < remaining) begin
        data[BYTE_W*(W-1-i) +: BYTE_W] = base_s + BYTE_W'(i);
      end else begin
        data[BYTE_W*(W-1-i) +: BYTE_W] = {BYTE_W{1'b0}};
      end
    end
  end

  // Last-beat detection and empty count.
  always_comb begin
    if (remaining <= CNT_W'(W)) begin
      last  = 1'b1;
      empty = EMPTY_W'(calc_empty(int'(remaining), W));
    end else begin
      last  = 1'b0;
      empty = '0;
    end
  end

endmodule

// File: rtl/avalon_st_msg_generator.sv
// Transmitter of one incrementing-byte message per start command, framed with
// sop/eop/empty on an Avalon-ST master port and paced by rdy backpressure.
module avalon_st_msg_generator
  import avalon_st_gen_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 4,
  parameter int MAX_MSG_LEN_BYTES   = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [$clog2(MAX_MSG_LEN_BYTES+1)-1:0] msg_len,
  input  logic [BYTE_W-1:0]                      first_byte,
  output logic                                   busy,
  output logic                                   done,
  avalon_st_if.master                            msg_out
);

  localparam int W       = DATA_WIDTH_IN_BYTES;
  localparam int LEN_W   = $clog2(MAX_MSG_LEN_BYTES + 1);
  localparam int CNT_W   = $clog2(MAX_MSG_LEN_BYTES + DATA_WIDTH_IN_BYTES);
  localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);
  localparam int DATA_W  = BYTE_W * DATA_WIDTH_IN_BYTES;

  gen_state_t         state_r, state_n;
  logic [LEN_W-1:0]   len_r, len_n;
  logic [BYTE_W-1:0]  first_r, first_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic [DATA_W-1:0]  data_r, data_n;
  logic               sop_r, sop_n;
  logic               eop_r, eop_n;
  logic [EMPTY_W-1:0] empty_r, empty_n;
  logic               valid_r, valid_n;
  logic               busy_r, busy_n;
  logic               done_r, done_n;

  logic [BYTE_W-1:0]  bld_first_s;
  logic [CNT_W-1:0]   bld_cnt_s;
  logic [CNT_W-1:0]   bld_rem_s;
  logic [DATA_W-1:0]  bld_data_s;
  logic [EMPTY_W-1:0] bld_empty_s;
  logic               bld_last_s;
  logic               len_ok_s;
  logic               xfer_s;

  assign len_ok_s = (msg_len != {LEN_W{1'b0}}) && (msg_len <= LEN_W'(MAX_MSG_LEN_BYTES));
  assign xfer_s   = valid_r && msg_out.rdy;

  // Beat builder inputs: the first beat comes straight from the start inputs.
  always_comb begin
    if (state_r == IDLE) begin
      bld_first_s = first_byte;
      bld_cnt_s   = {CNT_W{1'b0}};
      bld_rem_s   = CNT_W'(msg_len);
    end else begin
      bld_first_s = first_r;
      bld_cnt_s   = cnt_r;
      bld_rem_s   = CNT_W'(len_r) - cnt_r;
    end
  end

  avalon_st_pattern_beat #(
    .W       (W),
    .CNT_W   (CNT_W),
    .EMPTY_W (EMPTY_W)
  ) u_beat (
    .first_byte (bld_first_s),
    .byte_cnt   (bld_cnt_s),
    .remaining  (bld_rem_s),
    .data       (bld_data_s),
    .empty      (bld_empty_s),
    .last       (bld_last_s)
  );

  // Next-state and next-output logic; the registered beat only advances on a handshake.
  always_comb begin
    state_n = state_r;
    len_n   = len_r;
    first_n = first_r;
    cnt_n   = cnt_r;
    data_n  = data_r;
    sop_n   = sop_r;
    eop_n   = eop_r;
    empty_n = empty_r;
    valid_n = valid_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && len_ok_s) begin
          len_n   = msg_len;
          first_n = first_byte;
          cnt_n   = CNT_W'(W);
          data_n  = bld_data_s;
          empty_n = bld_empty_s;
          sop_n   = 1'b1;
          eop_n   = bld_last_s;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = SEND;
        end else if (start) begin
          done_n = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      SEND: begin
        if (xfer_s && eop_r) begin
          data_n  = '0;
          sop_n   = 1'b0;
          eop_n   = 1'b0;
          empty_n = '0;
          valid_n = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (xfer_s) begin
          cnt_n   = cnt_r + CNT_W'(W);
          data_n  = bld_data_s;
          empty_n = bld_empty_s;
          sop_n   = 1'b0;
          eop_n   = bld_last_s;
        end else begin
          state_n = SEND;
        end
      end
      default: begin
        data_n  = '0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        empty_n = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      len_r   <= '0;
      first_r <= '0;
      cnt_r   <= '0;
      data_r  <= '0;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
      empty_r <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      len_r   <= len_n;
      first_r <= first_n;
      cnt_r   <= cnt_n;
      data_r  <= data_n;
      sop_r   <= sop_n;
      eop_r   <= eop_n;
      empty_r <= empty_n;
      valid_r <= valid_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
    end
  end

  assign msg_out.data  = data_r;
  assign msg_out.sop   = sop_r;
  assign msg_out.eop   = eop_r;
  assign msg_out.empty = empty_r;
  assign msg_out.valid = valid_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_avalon_st_msg_generator.sv
// Directed bench for avalon_st_msg_generator with hand-computed beats.
`timescale 1ns/1ps
module tb_avalon_st_msg_generator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [10:0] msg_len;
  logic [7:0]  first_byte;
  logic        busy;
  logic        done;
  int          total;
  int          bad;
  int          xfer_cnt;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) bus ();

  avalon_st_msg_generator #(
    .DATA_WIDTH_IN_BYTES (4),
    .MAX_MSG_LEN_BYTES   (1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .msg_len    (msg_len),
    .first_byte (first_byte),
    .busy       (busy),
    .done       (done),
    .msg_out    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.valid && bus.rdy) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_msg(input logic [10:0] len, input logic [7:0] fb);
    start      = 1'b1;
    msg_len    = len;
    first_byte = fb;
    step();
    start = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input logic s, input logic e,
                      input logic [1:0] emp);
    chk({tag, ".valid"}, 64'(bus.valid), 64'd1);
    chk({tag, ".data"},  64'(bus.data),  64'(d));
    chk({tag, ".sop"},   64'(bus.sop),   64'(s));
    chk({tag, ".eop"},   64'(bus.eop),   64'(e));
    chk({tag, ".empty"}, 64'(bus.empty), 64'(emp));
    chk({tag, ".busy"},  64'(busy),      64'd1);
  endtask

  task automatic idle_done(input string tag);
    chk({tag, ".valid"}, 64'(bus.valid), 64'd0);
    chk({tag, ".busy"},  64'(busy),      64'd0);
    chk({tag, ".done"},  64'(done),      64'd1);
  endtask

  initial begin
    total = 0; bad = 0; xfer_cnt = 0;
    rst = 1'b1; start = 1'b0; msg_len = 11'd0; first_byte = 8'd0; bus.rdy = 1'b1;
    step(); step();
    chk("rst.valid", 64'(bus.valid), 64'd0);
    chk("rst.sop",   64'(bus.sop),   64'd0);
    chk("rst.eop",   64'(bus.eop),   64'd0);
    chk("rst.empty", 64'(bus.empty), 64'd0);
    chk("rst.data",  64'(bus.data),  64'd0);
    chk("rst.busy",  64'(busy),      64'd0);
    chk("rst.done",  64'(done),      64'd0);
    rst = 1'b0;
    step();

    // 10 bytes from 0x00: three beats, empty=2 on the last
    start_msg(11'd10, 8'h00);
    beat("m10.b0", 32'h00010203, 1'b1, 1'b0, 2'd0); step();
    beat("m10.b1", 32'h04050607, 1'b0, 1'b0, 2'd0); step();
    beat("m10.b2", 32'h08090000, 1'b0, 1'b1, 2'd2); step();
    idle_done("m10.end"); step();
    chk("m10.done_pulse", 64'(done), 64'd0);

    // single beat with mod-256 wrap
    start_msg(11'd4, 8'hFE);
    beat("m4.b0", 32'hFEFF0001, 1'b1, 1'b1, 2'd0); step();
    idle_done("m4.end"); step();

    // backpressure: first beat held across two stalled cycles
    bus.rdy = 1'b0;
    xfer_cnt = 0;
    start_msg(11'd8, 8'h10);
    beat("bp.b0", 32'h10111213, 1'b1, 1'b0, 2'd0); step();
    beat("bp.hold1", 32'h10111213, 1'b1, 1'b0, 2'd0); step();
    beat("bp.hold2", 32'h10111213, 1'b1, 1'b0, 2'd0);
    bus.rdy = 1'b1; step();
    beat("bp.b1", 32'h14151617, 1'b0, 1'b1, 2'd0); step();
    idle_done("bp.end");
    chk("bp.xfers", 64'(xfer_cnt), 64'd2);
    step();

    // zero and oversize lengths: no beats, done pulse only
    start_msg(11'd0, 8'h55);
    idle_done("len0"); step();
    chk("len0.after_valid", 64'(bus.valid), 64'd0);
    start_msg(11'd1025, 8'h55);
    idle_done("len1025"); step();

    // start while busy is ignored
    start_msg(11'd6, 8'h30);
    beat("ign.b0", 32'h30313233, 1'b1, 1'b0, 2'd0);
    start = 1'b1; msg_len = 11'd2; first_byte = 8'hAA;
    step();
    start = 1'b0;
    beat("ign.b1", 32'h34350000, 1'b0, 1'b1, 2'd2); step();
    idle_done("ign.end"); step();
    chk("ign.no_restart", 64'(bus.valid), 64'd0);

    // async reset during a stalled middle beat
    start_msg(11'd12, 8'h40);
    beat("rs.b0", 32'h40414243, 1'b1, 1'b0, 2'd0);
    step();
    bus.rdy = 1'b0;
    beat("rs.b1", 32'h44454647, 1'b0, 1'b0, 2'd0);
    step();
    rst = 1'b1;
    #1;
    chk("rs.valid", 64'(bus.valid), 64'd0);
    chk("rs.sop",   64'(bus.sop),   64'd0);
    chk("rs.eop",   64'(bus.eop),   64'd0);
    chk("rs.busy",  64'(busy),      64'd0);
    chk("rs.data",  64'(bus.data),  64'd0);
    step();
    chk("rs.done", 64'(done), 64'd0);
    rst = 1'b0; bus.rdy = 1'b1;
    step();
    start_msg(11'd5, 8'h20);
    beat("rs5.b0", 32'h20212223, 1'b1, 1'b0, 2'd0); step();
    beat("rs5.b1", 32'h24000000, 1'b0, 1'b1, 2'd3); step();
    idle_done("rs5.end"); step();

    // back-to-back: start in the done cycle is accepted
    start_msg(11'd4, 8'h50);
    beat("bb.b0", 32'h50515253, 1'b1, 1'b1, 2'd0); step();
    idle_done("bb.done");
    start_msg(11'd3, 8'h60);
    beat("bb2.b0", 32'h60616200, 1'b1, 1'b1, 2'd1); step();
    idle_done("bb2.end"); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
